data_memory_ctrl: RTL and testbench

- Load/store sequencer between the core's load/store stage and the word-wide `data_memory`.
- Accepts one byte, halfword or word request at a time over a valid/ready handshake.
- Loads: issues the word read, then extracts and sign- or zero-extends the lane.
- Sub-word stores: performs read-modify-write. Misaligned and out-of-range accesses are flagged without touching memory.

---
 rtl/data_memory_ctrl_pkg.sv | 27 ++
 rtl/data_memory_lane.sv | 51 +++++
 rtl/data_memory_ctrl.sv | 130 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the load/store sequencer.
// Holds the access-size encodings, the controller state encodings and the
// default memory size.
package data_memory_ctrl_pkg;

  // Access size as presented on req_size_i.
  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_RD   = 3'd1,
    S_LD_CAP  = 3'd2,
    S_RMW_RD  = 3'd3,
    S_RMW_MRG = 3'd4,
    S_ST_WR   = 3'd5,
    S_RESP    = 3'd6
  } state_e;

  localparam int unsigned DEFAULT_MEM_BYTES = 1024;

endpackage

// File: rtl/data_memory_lane.sv
// Byte/halfword lane logic for the data memory controller (combinational).
// Ports:
//   word        - word read from memory
//   wdata       - store data, right-aligned
//   addr_lo     - low two address bits selecting the lane
//   size        - access size
//   is_unsigned - zero-extend (1) or sign-extend (0) sub-word loads
//   ld_data     - extracted and extended load result
//   merged      - word with the addressed lane replaced by store data
module data_memory_lane
  import data_memory_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_ext;
  logic        half_ext;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    byte_ext = ~is_unsigned & byte_sel[7];
    half_ext = ~is_unsigned & half_sel[15];

    ld_data = word;
    unique case (size)
      SIZE_BYTE: ld_data = {{24{byte_ext}}, byte_sel};
      SIZE_HALF: ld_data = {{16{half_ext}}, half_sel};
      default:   ld_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    unique case (size)
      SIZE_BYTE: merged[{addr_lo, 3'b000} +: 8]        = wdata[7:0];
      SIZE_HALF: merged[{addr_lo[1], 4'b0000} +: 16]   = wdata[15:0];
      SIZE_WORD: merged = wdata;
      default:   merged = word;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Load/store sequencer between the core's load/store stage and a word-wide
// synchronous data memory. One request at a time over valid/ready; loads read
// and extend a lane, sub-word stores read-modify-write, and misaligned,
// illegal-size or out-of-range requests complete with an error and no strobe.
// Ports:
//   clock_i, reset_n_i          - clock, async active-low reset
//   req_*                       - request handshake and fields
//   rsp_valid_o/rdata_o/err_o   - one-cycle completion
//   mem_*                       - word address, write data/strobe, read strobe/data
module data_memory_ctrl
  import data_memory_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = DEFAULT_MEM_BYTES,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wr_data_o,
  output logic                  mem_wr_enable_o,
  output logic                  mem_rd_enable_o,
  input  logic [31:0]           mem_rd_data_i
);

  // One extra bit so the range check stays exact for any ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  size_e                 size_q;
  logic                  uns_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic        accept;
  logic        req_err;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign req_ready_o = reset_n_i && (state_q == S_IDLE);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    req_err = 1'b0;
    if (req_size_i == SIZE_ILLEGAL)                       req_err = 1'b1;
    if (req_size_i == SIZE_HALF && req_addr_i[0])         req_err = 1'b1;
    if (req_size_i == SIZE_WORD && req_addr_i[1:0] != '0) req_err = 1'b1;
    if ({1'b0, req_addr_i} >= MEM_LIMIT)                  req_err = 1'b1;
  end

  data_memory_lane u_lane (
    .word        (mem_rd_data_i),
    .wdata       (wdata_q),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ld_data     (ld_data),
    .merged      (merged)
  );

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                      state_d = S_RESP;
          else if (!req_we_i)               state_d = S_LD_RD;
          else if (req_size_i == SIZE_WORD) state_d = S_ST_WR;
          else                              state_d = S_RMW_RD;
        end
      end
      S_LD_RD:   state_d = S_LD_CAP;
      S_LD_CAP:  state_d = S_RESP;
      S_RMW_RD:  state_d = S_RMW_MRG;
      S_RMW_MRG: state_d = S_ST_WR;
      S_ST_WR:   state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Request fields are captured once at acceptance; wdata_q later doubles as
  // the merged word register so ST_WR always drives from one source.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_q  <= '0;
      size_q  <= SIZE_BYTE;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_i;
        size_q  <= size_e'(req_size_i);
        uns_q   <= req_unsigned_i;
        wdata_q <= req_wdata_i;
        rdata_q <= '0;
        err_q   <= req_err;
      end
      if (state_q == S_LD_CAP)  rdata_q <= ld_data;
      if (state_q == S_RMW_MRG) wdata_q <= merged;
    end
  end

  assign rsp_valid_o     = (state_q == S_RESP);
  assign rsp_rdata_o     = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o       = rsp_valid_o & err_q;
  assign mem_addr_o      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wr_data_o   = wdata_q;
  assign mem_wr_enable_o = (state_q == S_ST_WR);
  assign mem_rd_enable_o = (state_q == S_LD_RD) || (state_q == S_RMW_RD);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed testbench for data_memory_ctrl with a word-wide synchronous memory
// model, strobe counters and hand-computed expectations.
module tb_data_memory_ctrl;
  import data_memory_ctrl_pkg::*;

  logic        clock_i = 1'b0;
  logic        reset_n_i;
  logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] mem_addr_o, mem_wr_data_o, mem_rd_data_i;
  logic        mem_wr_enable_o, mem_rd_enable_o;

  data_memory_ctrl #(.MEM_BYTES(1024), .ADDR_WIDTH(32)) dut (
    .clock_i         (clock_i),
    .reset_n_i       (reset_n_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_we_i        (req_we_i),
    .req_size_i      (req_size_i),
    .req_unsigned_i  (req_unsigned_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_rdata_o     (rsp_rdata_o),
    .rsp_err_o       (rsp_err_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wr_data_o   (mem_wr_data_o),
    .mem_wr_enable_o (mem_wr_enable_o),
    .mem_rd_enable_o (mem_rd_enable_o),
    .mem_rd_data_i   (mem_rd_data_i)
  );

  always #5 clock_i = ~clock_i;

  // Memory model with a backdoor write port for preloading.
  logic [31:0] mem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;
  int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  logic [31:0] last_wr_addr = '0;

  always @(posedge clock_i) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    if (mem_wr_enable_o) begin
      mem[mem_addr_o[9:2]] <= mem_wr_data_o;
      wr_cnt               <= wr_cnt + 1;
      last_wr_addr         <= mem_addr_o;
    end
    if (mem_rd_enable_o) begin
      mem_rd_data_i <= mem[mem_addr_o[9:2]];
      rd_cnt        <= rd_cnt + 1;
    end
    if (mem_rd_enable_o && mem_wr_enable_o) both_cnt <= both_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    @(negedge clock_i);
    bd_idx  = idx[7:0];
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clock_i);
    bd_we   = 1'b0;
  endtask

  // Issue one request, scramble the inputs right after acceptance and wait
  // (bounded) for the response. lat = cycles from accept edge to rsp_valid.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int drd, output int dwr);
    int n, rd0, wr0;
    @(negedge clock_i);
    req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 20) begin @(negedge clock_i); n++; end
    @(posedge clock_i);
    #1;
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_valid_i = 1'b0; req_we_i = ~we; req_size_i = ~size; req_unsigned_i = ~uns;
    req_addr_i = ~addr; req_wdata_i = ~wdata;
    lat = -1; rdata = 'x; err = 1'bx;
    for (int c = 1; c <= 12; c++) begin
      if (rsp_valid_o) begin lat = c; rdata = rsp_rdata_o; err = rsp_err_o; break; end
      @(posedge clock_i);
      #1;
    end
    drd = rd_cnt - rd0;
    dwr = wr_cnt - wr0;
  endtask

  int          lat, drd, dwr, n, wr0;
  logic [31:0] rd;
  logic        er;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    string       tag;
  } err_vec_t;
  err_vec_t evs [4];

  initial begin
    reset_n_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = '0;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_wr_en", mem_wr_enable_o, 0);
    chk("rst_rd_en", mem_rd_enable_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    for (int i = 0; i < 4; i++) poke(i, 32'h0);
    poke(255, 32'h8000_0000);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    @(posedge clock_i); #1;
    chk("post_rst_ready", req_ready_o, 1);

    // SW then LW
    do_req(1, SIZE_WORD, 0, 32'h4, 32'hDEAD_BEEF, lat, rd, er, drd, dwr);
    chk("sw_lat", 32'(lat), 2);
    chk("sw_err", er, 0);
    chk("sw_wr_strobes", 32'(dwr), 1);
    chk("sw_rd_strobes", 32'(drd), 0);
    chk("sw_wr_addr", last_wr_addr, 32'h4);
    chk("sw_mem", mem[1], 32'hDEAD_BEEF);
    do_req(0, SIZE_WORD, 1, 32'h4, 32'h0, lat, rd, er, drd, dwr);
    chk("lw_lat", 32'(lat), 3);
    chk("lw_data", rd, 32'hDEAD_BEEF);
    chk("lw_err", er, 0);
    chk("lw_rd_strobes", 32'(drd), 1);
    chk("lw_wr_strobes", 32'(dwr), 0);

    // SB read-modify-write, upper wdata bits ignored
    poke(2, 32'h1122_3344);
    do_req(1, SIZE_BYTE, 0, 32'hA, 32'h1234_56AA, lat, rd, er, drd, dwr);
    chk("sb_lat", 32'(lat), 4);
    chk("sb_rd_strobes", 32'(drd), 1);
    chk("sb_wr_strobes", 32'(dwr), 1);
    chk("sb_rdata", rd, 32'h0);
    chk("sb_mem", mem[2], 32'h11AA_3344);
    do_req(0, SIZE_BYTE, 1, 32'hA, 32'h0, lat, rd, er, drd, dwr);
    chk("lbu_a", rd, 32'h0000_00AA);
    do_req(0, SIZE_BYTE, 0, 32'hA, 32'h0, lat, rd, er, drd, dwr);
    chk("lb_a", rd, 32'hFFFF_FFAA);
    do_req(0, SIZE_BYTE, 0, 32'hB, 32'h0, lat, rd, er, drd, dwr);
    chk("lb_b_pos", rd, 32'h0000_0011);
    do_req(0, SIZE_HALF, 1, 32'h8, 32'h0, lat, rd, er, drd, dwr);
    chk("lhu_8", rd, 32'h0000_3344);

    // SH into upper half
    do_req(1, SIZE_HALF, 0, 32'hE, 32'hFFFF_8001, lat, rd, er, drd, dwr);
    chk("sh_lat", 32'(lat), 4);
    chk("sh_mem", mem[3], 32'h8001_0000);
    do_req(0, SIZE_HALF, 0, 32'hE, 32'h0, lat, rd, er, drd, dwr);
    chk("lh_e", rd, 32'hFFFF_8001);
    do_req(0, SIZE_HALF, 1, 32'hE, 32'h0, lat, rd, er, drd, dwr);
    chk("lhu_e", rd, 32'h0000_8001);
    do_req(0, SIZE_HALF, 0, 32'hC, 32'h0, lat, rd, er, drd, dwr);
    chk("lh_c", rd, 32'h0000_0000);

    // Last valid byte address
    do_req(0, SIZE_BYTE, 0, 32'h3FF, 32'h0, lat, rd, er, drd, dwr);
    chk("lb_top_err", er, 0);
    chk("lb_top_data", rd, 32'hFFFF_FF80);

    // Error cases
    evs[0] = '{we: 1'b0, size: SIZE_WORD,    addr: 32'h2,   tag: "err_lw_2"};
    evs[1] = '{we: 1'b1, size: SIZE_HALF,    addr: 32'h1,   tag: "err_sh_1"};
    evs[2] = '{we: 1'b0, size: SIZE_ILLEGAL, addr: 32'h0,   tag: "err_size3"};
    evs[3] = '{we: 1'b0, size: SIZE_WORD,    addr: 32'd1024, tag: "err_range"};
    foreach (evs[i]) begin
      do_req(evs[i].we, evs[i].size, 0, evs[i].addr, 32'hFFFF_FFFF, lat, rd, er, drd, dwr);
      chk({evs[i].tag, "_lat"}, 32'(lat), 1);
      chk({evs[i].tag, "_err"}, er, 1);
      chk({evs[i].tag, "_rdata"}, rd, 0);
      chk({evs[i].tag, "_strobes"}, 32'(drd + dwr), 0);
    end
    chk("err_mem0", mem[0], 32'h0);
    chk("err_mem1", mem[1], 32'hDEAD_BEEF);

    // Back-to-back loads with req_valid held
    @(negedge clock_i);
    req_we_i = 0; req_size_i = SIZE_WORD; req_unsigned_i = 0; req_addr_i = 32'h4;
    req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 20) begin @(negedge clock_i); n++; end
    @(posedge clock_i); #1;
    req_size_i = SIZE_BYTE; req_unsigned_i = 1'b1; req_addr_i = 32'hA;
    chk("b2b_c1_ready", req_ready_o, 0);
    @(posedge clock_i); #1;
    chk("b2b_c2_ready", req_ready_o, 0);
    @(posedge clock_i); #1;
    chk("b2b_c3_ready", req_ready_o, 0);
    chk("b2b_c3_valid", rsp_valid_o, 1);
    chk("b2b_first_data", rsp_rdata_o, 32'hDEAD_BEEF);
    @(posedge clock_i); #1;
    chk("b2b_c4_ready", req_ready_o, 1);
    chk("b2b_c4_valid", rsp_valid_o, 0);
    @(posedge clock_i); #1;
    chk("b2b_c5_ready", req_ready_o, 0);
    req_valid_i = 1'b0;
    @(posedge clock_i); #1;
    chk("b2b_c6_valid", rsp_valid_o, 0);
    @(posedge clock_i); #1;
    chk("b2b_c7_valid", rsp_valid_o, 1);
    chk("b2b_second_data", rsp_rdata_o, 32'h0000_00AA);

    // Reset during RMW_MRG of SB @0x0
    poke(0, 32'h5566_7788);
    @(negedge clock_i);
    req_we_i = 1; req_size_i = SIZE_BYTE; req_unsigned_i = 0; req_addr_i = 32'h0;
    req_wdata_i = 32'h99; req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 20) begin @(negedge clock_i); n++; end
    @(posedge clock_i); #1;
    req_valid_i = 1'b0;
    @(posedge clock_i); #1;
    wr0 = wr_cnt;
    reset_n_i = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid_o, 0);
    chk("arst_wr_en", mem_wr_enable_o, 0);
    chk("arst_rd_en", mem_rd_enable_o, 0);
    chk("arst_ready", req_ready_o, 0);
    chk("arst_wr_data", mem_wr_data_o, 0);
    repeat (3) @(posedge clock_i);
    #1;
    chk("arst_hold_valid", rsp_valid_o, 0);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    #1;
    chk("arst_rel_ready", req_ready_o, 1);
    @(posedge clock_i); #1;
    chk("arst_after_ready", req_ready_o, 1);
    chk("arst_after_valid", rsp_valid_o, 0);
    chk("arst_no_write", 32'(wr_cnt - wr0), 0);
    chk("arst_mem0", mem[0], 32'h5566_7788);

    chk("never_rd_and_wr", 32'(both_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
